// File: rtl/divider8_seq_pkg.sv
// Shared definitions for the sequential restoring divider.
package divider8_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam int unsigned WIDTH_DEF = 8;

    // Step counter must hold the value WIDTH itself.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    localparam int unsigned CNT_W_DEF = cnt_width(WIDTH_DEF);

endpackage

// File: rtl/divider8_seq_sub_stage.sv
// Ripple-carry borrow subtractor: D = X - Y computed as X + ~Y + 1.
module sub_stage
    import divider8_seq_pkg::*;
#(
    parameter int unsigned N = WIDTH_DEF + 1
) (
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    output logic [N-1:0] D,
    output logic         NoBorrow
);

    logic [N-1:0] y_inv;

    assign y_inv = ~Y;

    // Chain of 1-bit full-adder cells; carry-in of 1 completes the two's complement.
    always_comb begin
        logic c;
        c = 1'b1;
        D = '0;
        for (int i = 0; i < int'(N); i++) begin
            D[i] = X[i] ^ y_inv[i] ^ c;
            c    = (X[i] & y_inv[i]) | (c & (X[i] ^ y_inv[i]));
        end
        NoBorrow = c;
    end

endmodule

// File: rtl/divider8_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
module divider8_seq
    import divider8_seq_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             DivZero
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;       // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   shifted_c;
    logic [WIDTH:0]   diff_c;
    logic             no_borrow_c;
    logic             diff_msb_unused;

    assign shifted_c = {rem_q, a_q[WIDTH-1]};

    sub_stage #(
        .N(WIDTH + 1)
    ) u_sub (
        .X       (shifted_c),
        .Y       ({1'b0, b_q}),
        .D       (diff_c),
        .NoBorrow(no_borrow_c)
    );

    // A kept difference is always below B, so its top bit is zero.
    assign diff_msb_unused = diff_c[WIDTH];

    // Next-state, datapath update and registered output flags.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        q_d     = q_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    if (B != '0) begin
                        a_d     = A;
                        b_d     = B;
                        rem_d   = '0;
                        cnt_d   = CNT_W'(WIDTH);
                        dz_d    = 1'b0;
                        state_d = CALC;
                    end else begin
                        q_d     = '1;
                        r_d     = A;
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            CALC: begin
                if (no_borrow_c) begin
                    rem_d = diff_c[WIDTH-1:0];
                    a_d   = {a_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted_c[WIDTH-1:0];
                    a_d   = {a_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    q_d     = a_d;
                    r_d     = rem_d;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Q       = q_q;
    assign R       = r_q;
    assign DivZero = dz_q;

endmodule

// File: tb/tb_divider8_seq.sv
// Self-checking bench for divider8_seq: directed table, corner sequences, random sweep.
module tb_divider8_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       busy;
    logic       done;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;

    int vectors     = 0;
    int miscompares = 0;
    int done_seen   = 0;
    int done_expect = 0;

    divider8_seq #(.WIDTH(8)) dut (
        .CLK    (clk),
        .RST    (rst),
        .Start  (start),
        .A      (a_in),
        .B      (b_in),
        .Busy   (busy),
        .Done   (done),
        .Q      (q),
        .R      (r),
        .DivZero(dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_seen++;
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         lat;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer division, with the divide-by-zero convention.
    function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] eq, output logic [7:0] er,
                                  output logic edz, output int elat);
        if (b == 8'd0) begin
            eq = 8'hFF; er = a; edz = 1'b1; elat = 1;
        end else begin
            eq = 8'(int'(a) / int'(b)); er = 8'(int'(a) % int'(b)); edz = 1'b0; elat = 9;
        end
    endfunction

    // Called at a negedge in IDLE; returns at a negedge in IDLE.
    // glitch > 0 drives a Start with A=9,B=9 during that cycle, which must be ignored.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er,
                          input logic edz, input int elat, input int glitch);
        int lat;
        int busy_ok;
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        done_expect++;
        @(negedge clk);
        start   = 1'b0;
        lat     = 0;
        busy_ok = 1;
        for (int k = 1; k <= 20; k++) begin
            if (!busy) busy_ok = 0;
            if (done) begin
                lat = k;
                break;
            end
            if (k == glitch) begin
                start = 1'b1; a_in = 8'd9; b_in = 8'd9;
            end else begin
                start = 1'b0; a_in = 8'($urandom); b_in = 8'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("latency", lat, elat);
        chk("busy_during_op", busy_ok, 1);
        chk("q_at_done", int'(q), int'(eq));
        chk("r_at_done", int'(r), int'(er));
        chk("divzero_at_done", int'(dz), int'(edz));
        @(negedge clk);
        chk("done_one_cycle", int'(done), 0);
        chk("busy_after_done", int'(busy), 0);
        for (int h = 0; h < 2; h++) begin
            a_in = 8'($urandom);
            b_in = 8'($urandom);
            @(negedge clk);
            chk("q_hold_idle", int'(q), int'(eq));
            chk("r_hold_idle", int'(r), int'(er));
            chk("divzero_hold_idle", int'(dz), int'(edz));
        end
    endtask

    initial begin
        logic [7:0] ra, rb, eq, er;
        logic       edz;
        int         elat;
        int         sel;

        tbl[0]  = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 9};
        tbl[1]  = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 9};
        tbl[2]  = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 9};
        tbl[3]  = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 9};
        tbl[4]  = '{8'd37,  8'd0,   8'd255, 8'd37,  1'b1, 1};
        tbl[5]  = '{8'd37,  8'd5,   8'd7,   8'd2,   1'b0, 9};
        tbl[6]  = '{8'd0,   8'd1,   8'd0,   8'd0,   1'b0, 9};
        tbl[7]  = '{8'd0,   8'd0,   8'd255, 8'd0,   1'b1, 1};
        tbl[8]  = '{8'd1,   8'd255, 8'd0,   8'd1,   1'b0, 9};
        tbl[9]  = '{8'd254, 8'd255, 8'd0,   8'd254, 1'b0, 9};
        tbl[10] = '{8'd128, 8'd2,   8'd64,  8'd0,   1'b0, 9};
        tbl[11] = '{8'd200, 8'd13,  8'd15,  8'd5,   1'b0, 9};

        rst   = 1'b1;
        start = 1'b1;
        a_in  = 8'd77;
        b_in  = 8'd3;
        repeat (2) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_q", int'(q), 0);
        chk("reset_r", int'(r), 0);
        chk("reset_divzero", int'(dz), 0);
        rst = 1'b0;

        // Directed table; first Start lands on the first edge after reset release.
        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].lat, 0);
        end

        // Start during CALC is ignored.
        run_op(8'd200, 8'd3, 8'd66, 8'd2, 1'b0, 9, 4);

        // Reset in cycle 5 aborts the operation without a Done.
        start = 1'b1; a_in = 8'd200; b_in = 8'd3;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk("no_done_before_abort", int'(done), 0);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_q", int'(q), 0);
        chk("abort_r", int'(r), 0);
        chk("abort_divzero", int'(dz), 0);
        rst = 1'b0;
        run_op(8'd50, 8'd6, 8'd8, 8'd2, 1'b0, 9, 0);

        // Random sweep against the arithmetic model.
        for (int n = 0; n < 3000; n++) begin
            sel = int'($urandom_range(0, 15));
            ra  = 8'($urandom);
            if (sel == 0)      rb = 8'd0;
            else if (sel < 4)  rb = 8'($urandom_range(1, 15));
            else if (sel == 4) rb = ra;
            else               rb = 8'($urandom);
            model(ra, rb, eq, er, edz, elat);
            run_op(ra, rb, eq, er, edz, elat, 0);
        end

        chk("done_pulse_count", done_seen, done_expect);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
